alu_muldiv: RTL and testbench
=============================

Name: alu_muldiv

Overview:
- Parametrised, registered successor to the single-cycle datapath ALU.
- Single-cycle ops (add/sub, compares, shifts, boolean, pass) return a registered result 1 cycle after acceptance.
- Adds iterative signed/unsigned multiply and divide producing Hi/Lo pairs.
- Sits in the EX stage behind a valid/ready handshake, so the pipeline stalls on in_ready during mul/div.

Parameters:
- WIDTH, 32, operand/result width; must be ≥4 and a power of two.
- SHW, $clog2(WIDTH), shift-amount bits taken from B[SHW-1:0]; derived, not overridable.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands/op presented
- in_ready  out  1  block can accept; combinational, equals (state==IDLE)
- A  in  WIDTH  operand A (dividend/multiplicand)
- B  in  WIDTH  operand B (divisor/multiplier/shift amount)
- ALUOp  in  5  operation code
- out_valid  out  1  one-cycle pulse: Y/Hi/flags updated this cycle
- Y  out  WIDTH  result; Lo half/quotient for mul/div
- Hi  out  WIDTH  product high half or remainder; 0 for single-cycle ops
- z, v, n  out  1 each  zero, overflow, negative flags

Behaviour:
- Reset (async, reset_n=0): state=IDLE; Y, Hi, z, v, n, out_valid = 0; any op in flight is abandoned. Release takes effect at the next clk edge.
- Accept: at a clk edge with in_valid && in_ready. Inputs are sampled only at acceptance; later changes are ignored.
- Single-cycle ops (latency 1, state stays IDLE, back-to-back every cycle):
  - 00000 add; 00001 sub.
  - 00101 EQ, 00111 signed LT, 01101 signed LE; compare result is zero-extended to WIDTH.
  - 01000 SLL, 01001 SRL, 01011 SRA by B[SHW-1:0].
  - 11010 pass A; 11000 AND; 10001 NOR; 11110 OR; 11001 XNOR; 10110 XOR.
  - Undefined codes: Y=0.
  - Results wrap modulo 2^WIDTH. Hi=0.
  - Flags: z=(Y==0); n=Y[WIDTH-1]; v=signed overflow for add/sub, else 0.
- Multi-cycle ops: 10000 MULT (signed), 10010 MULTU, 10100 DIV (signed), 10011 DIVU.
  - State machine IDLE→CALC→FIX→IDLE.
  - IDLE: on accept of a mul/div op, latch operand magnitudes (absolute value if signed) and result-sign bits; set counter=WIDTH-1; go to CALC.
  - CALC: one shift-add (mul) or restoring-subtract (div) step per cycle, exactly WIDTH cycles; counter decrements; leave when counter==0.
  - FIX: apply sign correction (2's-complement negate) and special cases.
  - FIX→IDLE: register Y/Hi/flags and assert out_valid at that edge.
  - out_valid is high during the cycle beginning WIDTH+2 edges after the accept edge; in_ready is high again in that same cycle.
  - in_ready=0 from the accept edge until then. out_valid is never asserted while busy.
- Mul: {Hi,Y} = full 2*WIDTH-bit product; z=({Hi,Y}==0); n=Hi[WIDTH-1]; v=0.
- Div: Y=quotient truncated toward zero; Hi=remainder carrying the dividend's sign; z=(Y==0); n=Y[WIDTH-1]; v=0 except the special cases below.
- Divide-by-zero (B==0, DIV or DIVU): Y=all ones; Hi=A; v=1. Same latency as a normal divide.
- Signed overflow (DIV, A=MIN, B=-1): Y=MIN; Hi=0; v=1.
- Between results, Y/Hi/flags hold their last values.
- in_valid while in_ready=0 is ignored (no queuing).
- An accept in the same cycle as the out_valid pulse is legal and starts the next op.

Test Plan:
- Reset mid-op: accept MULT, drop reset_n at cycle 10 → all outputs 0 immediately; in_ready=1 after release; next ADD 1+2 → Y=3 at the following edge.
- Back-to-back single ops, WIDTH=32: ADD 0x7FFFFFFF+1 → Y=0x80000000, v=1, n=1. Next cycle SUB 5-5 → Y=0, z=1. Next cycle SRA 0x80000000 by 4 → Y=0xF8000000. Next cycle CMPLT -1<1 → Y=1. One result every cycle; in_ready stays 1.
- MULT -3*7 → Y=0xFFFFFFEB, Hi=0xFFFFFFFF, n=1, out_valid exactly 34 cycles after accept. MULTU 0xFFFFFFFF*0xFFFFFFFF → Hi=0xFFFFFFFE, Y=0x00000001.
- DIV -7/2 → Y=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU 100/7 → Y=14, Hi=2. in_ready low for the full 34-cycle window; in_valid pulses during the window are ignored.
- Special cases: DIVU 9/0 → Y=0xFFFFFFFF, Hi=9, v=1. DIV 0x80000000/0xFFFFFFFF → Y=0x80000000, Hi=0, v=1.
- WIDTH=8 instance: MULTU 0xFF*0x02 → Hi=0x01, Y=0xFE, out_valid 10 cycles after accept. SLL uses B[2:0] only: B=0x09 shifts by 1.

Source files
------------

// File: rtl/alu_muldiv.sv
// Registered EX-stage ALU with single-cycle ops and iterative signed/unsigned
// multiply and divide behind a valid/ready handshake.
module alu_muldiv #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       ALUOp,
  output logic             out_valid,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Hi,
  output logic             z,
  output logic             v,
  output logic             n
);

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_SUB   = 5'b00001;
  localparam logic [4:0] OP_EQ    = 5'b00101;
  localparam logic [4:0] OP_LT    = 5'b00111;
  localparam logic [4:0] OP_LE    = 5'b01101;
  localparam logic [4:0] OP_SLL   = 5'b01000;
  localparam logic [4:0] OP_SRL   = 5'b01001;
  localparam logic [4:0] OP_SRA   = 5'b01011;
  localparam logic [4:0] OP_PASS  = 5'b11010;
  localparam logic [4:0] OP_AND   = 5'b11000;
  localparam logic [4:0] OP_NOR   = 5'b10001;
  localparam logic [4:0] OP_OR    = 5'b11110;
  localparam logic [4:0] OP_XNOR  = 5'b11001;
  localparam logic [4:0] OP_XOR   = 5'b10110;
  localparam logic [4:0] OP_MULT  = 5'b10000;
  localparam logic [4:0] OP_MULTU = 5'b10010;
  localparam logic [4:0] OP_DIV   = 5'b10100;
  localparam logic [4:0] OP_DIVU  = 5'b10011;

  localparam int M = WIDTH - 1;
  localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   MIN_W    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [SHW-1:0]     CNT_ZERO = {SHW{1'b0}};
  localparam logic [SHW-1:0]     CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
  localparam logic [SHW-1:0]     CNT_TOP  = {SHW{1'b1}};

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state_r;
  logic [SHW-1:0]   cnt_r;
  logic             fix_ph_r;
  logic             is_div_r;
  logic             neg_q_r;
  logic             neg_r_r;
  logic             div0_r;
  logic             ovf_r;
  logic [WIDTH-1:0] opa_raw_r;
  logic [WIDTH-1:0] opb_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  logic [WIDTH-1:0] alu_y_s, sum_s, dif_s;
  logic             alu_v_s;
  logic [SHW-1:0]   sh_s;
  logic             multi_s, sgn_s, div_s;
  logic [WIDTH-1:0] mag_a_s, mag_b_s;
  logic [WIDTH:0]   add_s, rsh_s, diff_s;
  logic [WIDTH-1:0] step_hi_s, step_lo_s, fix_hi_s, fix_lo_s;
  logic             mz_s, mn_s, mv_s;

  assign in_ready = (state_r == IDLE);

  // Single-cycle result and overflow for the operation currently presented
  always_comb begin
    alu_y_s = ZERO_W;
    alu_v_s = 1'b0;
    sum_s   = A + B;
    dif_s   = A - B;
    sh_s    = B[SHW-1:0];
    case (ALUOp)
      OP_ADD:  begin
        alu_y_s = sum_s;
        alu_v_s = (A[M] == B[M]) && (sum_s[M] != A[M]);
      end
      OP_SUB:  begin
        alu_y_s = dif_s;
        alu_v_s = (A[M] != B[M]) && (dif_s[M] != A[M]);
      end
      OP_EQ:   alu_y_s = {{(WIDTH-1){1'b0}}, (A == B)};
      OP_LT:   alu_y_s = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_LE:   alu_y_s = {{(WIDTH-1){1'b0}}, ($signed(A) <= $signed(B))};
      OP_SLL:  alu_y_s = A << sh_s;
      OP_SRL:  alu_y_s = A >> sh_s;
      OP_SRA:  alu_y_s = $signed(A) >>> sh_s;
      OP_PASS: alu_y_s = A;
      OP_AND:  alu_y_s = A & B;
      OP_NOR:  alu_y_s = ~(A | B);
      OP_OR:   alu_y_s = A | B;
      OP_XNOR: alu_y_s = ~(A ^ B);
      OP_XOR:  alu_y_s = A ^ B;
      default: alu_y_s = ZERO_W;
    endcase
  end

  // Classify the presented op and form operand magnitudes for the iterative unit
  always_comb begin
    multi_s = 1'b0;
    sgn_s   = 1'b0;
    div_s   = 1'b0;
    case (ALUOp)
      OP_MULT:  begin multi_s = 1'b1; sgn_s = 1'b1; end
      OP_MULTU: begin multi_s = 1'b1; end
      OP_DIV:   begin multi_s = 1'b1; sgn_s = 1'b1; div_s = 1'b1; end
      OP_DIVU:  begin multi_s = 1'b1; div_s = 1'b1; end
      default:  begin multi_s = 1'b0; end
    endcase
    if (sgn_s && A[M]) mag_a_s = ~A + ONE_W;
    else               mag_a_s = A;
    if (sgn_s && B[M]) mag_b_s = ~B + ONE_W;
    else               mag_b_s = B;
  end

  // One shift-add (mul) or restoring-subtract (div) step on {hi_r, lo_r}
  always_comb begin
    add_s  = {(WIDTH+1){1'b0}};
    rsh_s  = {hi_r, lo_r[M]};
    diff_s = rsh_s - {1'b0, opb_r};
    if (is_div_r) begin
      if (!diff_s[WIDTH]) begin
        step_hi_s = diff_s[WIDTH-1:0];
        step_lo_s = {lo_r[WIDTH-2:0], 1'b1};
      end else begin
        step_hi_s = rsh_s[WIDTH-1:0];
        step_lo_s = {lo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      add_s     = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opb_r} : {(WIDTH+1){1'b0}});
      step_hi_s = add_s[WIDTH:1];
      step_lo_s = {add_s[0], lo_r[WIDTH-1:1]};
    end
  end

  // Sign correction and divide special cases, then the flags of the final pair
  always_comb begin
    if (!is_div_r) begin
      if (neg_q_r) {fix_hi_s, fix_lo_s} = ~{hi_r, lo_r} + ONE_2W;
      else         {fix_hi_s, fix_lo_s} = {hi_r, lo_r};
    end else if (div0_r) begin
      fix_lo_s = ONES_W;
      fix_hi_s = opa_raw_r;
    end else if (ovf_r) begin
      fix_lo_s = MIN_W;
      fix_hi_s = ZERO_W;
    end else begin
      fix_lo_s = neg_q_r ? (~lo_r + ONE_W) : lo_r;
      fix_hi_s = neg_r_r ? (~hi_r + ONE_W) : hi_r;
    end
    if (is_div_r) begin
      mz_s = (lo_r == ZERO_W);
      mn_s = lo_r[M];
      mv_s = div0_r | ovf_r;
    end else begin
      mz_s = ({hi_r, lo_r} == {2*WIDTH{1'b0}});
      mn_s = hi_r[M];
      mv_s = 1'b0;
    end
  end

  // Control FSM, iterative datapath registers and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      fix_ph_r  <= 1'b0;
      is_div_r  <= 1'b0;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      div0_r    <= 1'b0;
      ovf_r     <= 1'b0;
      opa_raw_r <= ZERO_W;
      opb_r     <= ZERO_W;
      hi_r      <= ZERO_W;
      lo_r      <= ZERO_W;
      out_valid <= 1'b0;
      Y         <= ZERO_W;
      Hi        <= ZERO_W;
      z         <= 1'b0;
      v         <= 1'b0;
      n         <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (in_valid && multi_s) begin
            is_div_r  <= div_s;
            neg_q_r   <= sgn_s & (A[M] ^ B[M]);
            neg_r_r   <= sgn_s & A[M];
            div0_r    <= div_s & (B == ZERO_W);
            ovf_r     <= (ALUOp == OP_DIV) && (A == MIN_W) && (B == ONES_W);
            opa_raw_r <= A;
            opb_r     <= mag_b_s;
            hi_r      <= ZERO_W;
            lo_r      <= mag_a_s;
            cnt_r     <= CNT_TOP;
            fix_ph_r  <= 1'b0;
            state_r   <= CALC;
          end else if (in_valid) begin
            Y         <= alu_y_s;
            Hi        <= ZERO_W;
            z         <= (alu_y_s == ZERO_W);
            n         <= alu_y_s[M];
            v         <= alu_v_s;
            out_valid <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          hi_r  <= step_hi_s;
          lo_r  <= step_lo_s;
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ZERO) state_r <= FIX;
          else                   state_r <= CALC;
        end
        FIX: begin
          // First FIX cycle corrects the pair in place; the second publishes it.
          if (!fix_ph_r) begin
            hi_r     <= fix_hi_s;
            lo_r     <= fix_lo_s;
            fix_ph_r <= 1'b1;
          end else begin
            Y         <= lo_r;
            Hi        <= hi_r;
            z         <= mz_s;
            n         <= mn_s;
            v         <= mv_s;
            out_valid <= 1'b1;
            fix_ph_r  <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv at WIDTH=32 and WIDTH=8.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A = 32'h0, B = 32'h0;
  logic [4:0]  ALUOp = 5'b00000;
  logic        out_valid;
  logic [31:0] Y, Hi;
  logic        z, v, n;

  logic        in_valid8 = 1'b0;
  logic        in_ready8;
  logic [7:0]  A8 = 8'h0, B8 = 8'h0;
  logic [4:0]  ALUOp8 = 5'b00000;
  logic        out_valid8;
  logic [7:0]  Y8, Hi8;
  logic        z8, v8, n8;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALUOp(ALUOp), .out_valid(out_valid), .Y(Y), .Hi(Hi),
    .z(z), .v(v), .n(n)
  );

  alu_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .A(A8), .B(B8), .ALUOp(ALUOp8), .out_valid(out_valid8), .Y(Y8), .Hi(Hi8),
    .z(z8), .v(v8), .n(n8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one single-cycle op and checks the result one edge later; in_valid stays high.
  task automatic single(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ey,
                        input logic ez, input logic ev, input logic en);
    in_valid = 1'b1; ALUOp = op; A = a; B = b;
    @(posedge clk); #1;
    check({tag, " Y"}, Y, ey);
    check({tag, " Hi"}, Hi, 32'h0);
    check({tag, " zvn"}, {z, v, n}, {ez, ev, en});
    check({tag, " valid/ready"}, {out_valid, in_ready}, 2'b11);
  endtask

  // Runs one mul/div op, optionally poking in_valid mid-window, and checks timing and result.
  task automatic multi(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ey, input logic [31:0] ehi,
                       input logic ez, input logic ev, input logic en, input bit poke);
    int lat;
    bit busy_ok;
    in_valid = 1'b1; ALUOp = op; A = a; B = b;
    @(posedge clk); #1;
    in_valid = 1'b0; A = 32'h0; B = 32'h0;
    lat = 0;
    busy_ok = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_ok = 1'b0;
      if (poke && (lat == 4 || lat == 20)) begin
        in_valid = 1'b1; ALUOp = 5'b00000; A = 32'h11; B = 32'h22;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check({tag, " latency"}, lat, 34);
    check({tag, " busy"}, busy_ok, 1'b1);
    check({tag, " ready"}, in_ready, 1'b1);
    check({tag, " Y"}, Y, ey);
    check({tag, " Hi"}, Hi, ehi);
    check({tag, " zvn"}, {z, v, n}, {ez, ev, en});
    @(posedge clk); #1;
    check({tag, " pulse"}, out_valid, 1'b0);
  endtask

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1;
    check("reset outs", {out_valid, Y, Hi, z, v, n}, 70'h0);
    check("reset ready", in_ready, 1'b1);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back single-cycle ops, one result per edge
    single("add ovf", 5'b00000, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b1, 1'b1);
    single("sub zero", 5'b00001, 32'h5, 32'h5, 32'h0, 1'b1, 1'b0, 1'b0);
    single("sra", 5'b01011, 32'h80000000, 32'h4, 32'hF8000000, 1'b0, 1'b0, 1'b1);
    single("lt", 5'b00111, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, 1'b0, 1'b0);
    single("le eq", 5'b01101, 32'h3, 32'h3, 32'h1, 1'b0, 1'b0, 1'b0);
    single("eq ne", 5'b00101, 32'h3, 32'h4, 32'h0, 1'b1, 1'b0, 1'b0);
    single("srl", 5'b01001, 32'h80000000, 32'h24, 32'h08000000, 1'b0, 1'b0, 1'b0);
    single("nor", 5'b10001, 32'h0F0F0000, 32'h000000FF, 32'hF0F0FF00, 1'b0, 1'b0, 1'b1);
    single("xor", 5'b10110, 32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0, 1'b0, 1'b0, 1'b1);
    single("undef", 5'b11111, 32'h12345678, 32'h1, 32'h0, 1'b1, 1'b0, 1'b0);
    single("sub ovf", 5'b00001, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("idle no pulse", out_valid, 1'b0);

    multi("mult", 5'b10000, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    multi("multu", 5'b10010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 1'b0);
    multi("div", 5'b10100, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1);
    multi("divu", 5'b10011, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    multi("divu by0", 5'b10011, 32'd9, 32'd0, 32'hFFFFFFFF, 32'd9, 1'b0, 1'b1, 1'b1, 1'b0);
    multi("div ovf", 5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    multi("div small", 5'b10100, 32'h7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h1, 1'b0, 1'b0, 1'b1, 1'b0);

    // WIDTH=8 instance: multiply latency and shift-amount truncation
    in_valid8 = 1'b1; ALUOp8 = 5'b10010; A8 = 8'hFF; B8 = 8'h02;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w8 multu latency", lat, 10);
    check("w8 multu Y", Y8, 8'hFE);
    check("w8 multu Hi", Hi8, 8'h01);
    check("w8 multu zvn", {z8, v8, n8}, 3'b000);
    in_valid8 = 1'b1; ALUOp8 = 5'b01000; A8 = 8'h53; B8 = 8'h09;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    check("w8 sll Y", Y8, 8'hA6);
    check("w8 sll Hi", Hi8, 8'h00);
    check("w8 sll zvn", {z8, v8, n8}, 3'b001);

    // Reset in the middle of a multiply
    in_valid = 1'b1; ALUOp = 5'b10000; A = 32'h5; B = 32'h6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset outs", {out_valid, Y, Hi, z, v, n}, 70'h0);
    check("midreset ready", in_ready, 1'b1);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    check("post reset ready", in_ready, 1'b1);
    check("post reset valid", out_valid, 1'b0);
    single("add after rst", 5'b00000, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
